bm_pack_buf: RTL

Parametrised bitmap pack buffer: accepts DW-bit words from the bitmap source over a valid/ready handshake and serialises them into a byte-wide circular RAM of 2^AW bytes. A consumer opens a read session with bm_req and pops bytes with bm_rd. On session open, reading starts a configurable number of words behind the write point. Writer overrun of a stalled reader drops the oldest byte and raises a sticky overflow flag. Sits in pack_top between the bitmap generator and the packet assembler.

---
 rtl/bm_pack_buf.sv | 79 +++++++
 1 files changed

// File: rtl/bm_pack_buf.sv
// bm_pack_buf: serialises DW-bit words into a byte-wide circular RAM and replays them to a byte consumer
// Ports:
//   clk_sys, rst_n          system clock, asynchronous active-low reset
//   bm_data/bm_vld/bm_rdy   word input handshake; bm_rdy while at most one byte of the current word remains
//   bm_req, bm_rd           read session level and pop request
//   bm_q, bm_qvld           popped byte, valid one cycle after the pop
//   level                   unread bytes, (waddr - raddr) mod 2^AW
//   ovf, clr_ovf            sticky overrun flag and its clear
module bm_pack_buf #(
  parameter int DW        = 32,
  parameter int AW        = 15,
  parameter int LOOKBACK  = 4,
  parameter int MSB_FIRST = 1
) (
  input  logic          clk_sys,
  input  logic          rst_n,
  input  logic [DW-1:0] bm_data,
  input  logic          bm_vld,
  output logic          bm_rdy,
  input  logic          bm_req,
  input  logic          bm_rd,
  output logic [7:0]    bm_q,
  output logic          bm_qvld,
  output logic [AW-1:0] level,
  output logic          ovf,
  input  logic          clr_ovf
);
  localparam int NB = DW / 8;
  localparam int CW = $clog2(NB + 1);
  localparam logic [AW-1:0] LB_OFS = AW'(LOOKBACK * NB);
  localparam logic [AW-1:0] ALIGN  = ~AW'(NB - 1);
  localparam logic [CW-1:0] NB_C   = CW'(NB);
  logic [DW-1:0] sr;
  logic [CW-1:0] cnt;
  logic [AW-1:0] waddr, raddr;
  logic [7:0]    mem [0:2**AW-1];
  logic [7:0]    rdata;
  logic          rd_seen, acc, wr, rd_go, drop;
  logic [7:0]    wbyte;
  assign bm_rdy = cnt <= CW'(1);
  assign acc    = bm_vld & bm_rdy;
  assign wr     = cnt != '0;
  assign wbyte  = MSB_FIRST ? sr[DW-1 -: 8] : sr[7:0];
  assign level  = waddr - raddr;
  assign rd_go  = bm_req & bm_rd & (level != '0);
  // a write into a full ring with no pop this cycle evicts the oldest byte
  assign drop   = wr & (&level) & ~rd_go;
  // bm_q reads as zero until the first pop after reset; the RAM register itself is not reset
  assign bm_q   = rd_seen ? rdata : 8'h00;
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      sr      <= '0;
      cnt     <= '0;
      waddr   <= '0;
      raddr   <= '0;
      ovf     <= 1'b0;
      bm_qvld <= 1'b0;
      rd_seen <= 1'b0;
    end else begin
      if (acc) begin
        sr  <= bm_data;
        cnt <= NB_C;
      end else if (wr) begin
        sr  <= MSB_FIRST ? sr << 8 : sr >> 8;
        cnt <= cnt - 1'b1;
      end
      waddr   <= waddr + AW'(wr);
      // outside a session the read pointer shadows the word-aligned write point minus the lookback
      raddr   <= bm_req ? raddr + AW'(rd_go | drop) : (waddr & ALIGN) - LB_OFS;
      ovf     <= drop | (ovf & ~clr_ovf);
      bm_qvld <= rd_go;
      rd_seen <= rd_seen | rd_go;
    end
  end
  always_ff @(posedge clk_sys) begin
    if (wr) mem[waddr] <= wbyte;
    if (rd_go) rdata <= mem[raddr];
  end
endmodule
